// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - Shared constants, Q2.14 twiddle table and helpers for the streaming FFT
package fft_pkg;

    localparam int TW_FRAC   = 14;
    localparam int MAX_LOG2N = 5;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    function automatic int out_width(input int data_w, input int log2n);
        return data_w + log2n;
    endfunction

    // Reverse all five bits, then drop the unused low end so only `bits` are mirrored.
    function automatic logic [4:0] bitrev(input logic [4:0] v, input int bits);
        logic [4:0] r;
        r = {v[0], v[1], v[2], v[3], v[4]};
        return r >> (MAX_LOG2N - bits);
    endfunction

    // cos(2*pi*k/32) in Q2.14
    function automatic logic signed [15:0] tw_cos(input logic [3:0] k);
        case (k)
            4'd0:  return 16'sd16384;
            4'd1:  return 16'sd16069;
            4'd2:  return 16'sd15137;
            4'd3:  return 16'sd13623;
            4'd4:  return 16'sd11585;
            4'd5:  return 16'sd9102;
            4'd6:  return 16'sd6270;
            4'd7:  return 16'sd3196;
            4'd8:  return 16'sd0;
            4'd9:  return -16'sd3196;
            4'd10: return -16'sd6270;
            4'd11: return -16'sd9102;
            4'd12: return -16'sd11585;
            4'd13: return -16'sd13623;
            4'd14: return -16'sd15137;
            default: return -16'sd16069;
        endcase
    endfunction

    // sin(2*pi*k/32) in Q2.14
    function automatic logic signed [15:0] tw_sin(input logic [3:0] k);
        case (k)
            4'd0:  return 16'sd0;
            4'd1:  return 16'sd3196;
            4'd2:  return 16'sd6270;
            4'd3:  return 16'sd9102;
            4'd4:  return 16'sd11585;
            4'd5:  return 16'sd13623;
            4'd6:  return 16'sd15137;
            4'd7:  return 16'sd16069;
            4'd8:  return 16'sd16384;
            4'd9:  return 16'sd16069;
            4'd10: return 16'sd15137;
            4'd11: return 16'sd13623;
            4'd12: return 16'sd11585;
            4'd13: return 16'sd9102;
            4'd14: return 16'sd6270;
            default: return 16'sd3196;
        endcase
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - Combinational radix-2 DIT butterfly with rounded Q2.14 twiddle multiply
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int AW   = 20,
    parameter int TW_W = 16
) (
    input  logic signed [AW-1:0]   a_re,
    input  logic signed [AW-1:0]   a_im,
    input  logic signed [AW-1:0]   b_re,
    input  logic signed [AW-1:0]   b_im,
    input  logic signed [TW_W-1:0] w_re,
    input  logic signed [TW_W-1:0] w_im,
    output logic signed [AW-1:0]   y0_re,
    output logic signed [AW-1:0]   y0_im,
    output logic signed [AW-1:0]   y1_re,
    output logic signed [AW-1:0]   y1_im
);
    localparam int PW = AW + TW_W;
    localparam logic signed [PW-1:0] RND = PW'(1 << (TW_FRAC - 1));

    logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, p_re, p_im;
    logic signed [AW-1:0] t_re, t_im;

    assign br_x = PW'(b_re);
    assign bi_x = PW'(b_im);
    assign wr_x = PW'(w_re);
    assign wi_x = PW'(w_im);

    // Complex product kept at full precision, rounded once per component.
    assign p_re = br_x * wr_x - bi_x * wi_x;
    assign p_im = br_x * wi_x + bi_x * wr_x;
    assign t_re = AW'((p_re + RND) >>> TW_FRAC);
    assign t_im = AW'((p_im + RND) >>> TW_FRAC);

    assign y0_re = a_re + t_re;
    assign y0_im = a_im + t_im;
    assign y1_re = a_re - t_re;
    assign y1_im = a_im - t_im;

endmodule

// File: rtl/fft_stream_core.sv
// rtl/fft_stream_core.sv - Iterative in-place radix-2 FFT with streaming load and natural-order unload
module fft_stream_core
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 3,
    parameter int TW_W   = 16,
    parameter int OUT_W  = out_width(DATA_W, LOG2N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     inverse,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_re,
    output logic signed [OUT_W-1:0]  out_im,
    output logic [LOG2N-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy
);
    localparam int N  = 1 << LOG2N;
    localparam int AW = OUT_W + 1;

    logic [1:0]             state;
    logic                   mode;
    logic [LOG2N-1:0]       cnt, bf, j_i, top_i, bot_i, load_addr;
    logic [2:0]             stage;
    logic [3:0]             tw_idx;
    logic signed [TW_W-1:0] w_re, w_im;
    logic signed [AW-1:0]   arr_re [N];
    logic signed [AW-1:0]   arr_im [N];
    logic signed [AW-1:0]   y0_re, y0_im, y1_re, y1_im;
    logic                   in_fire, last_bf, last_stage;

    assign in_ready   = (state == ST_LOAD) && !rst;
    assign in_fire    = in_valid && in_ready;
    assign busy       = (state != ST_LOAD);
    assign load_addr  = LOG2N'(bitrev(5'(cnt), LOG2N));
    assign last_bf    = (bf == LOG2N'(N / 2 - 1));
    assign last_stage = (stage == 3'(LOG2N - 1));

    // Pair addressing for stage s: span m = 2^s, top = group*2m + j, bottom = top + m.
    always_comb begin
        j_i    = bf & LOG2N'((1 << stage) - 1);
        top_i  = LOG2N'((bf >> stage) << (stage + 3'd1)) | j_i;
        bot_i  = top_i | LOG2N'(1 << stage);
        tw_idx = 4'(j_i) << (3'd4 - stage);
        w_re   = TW_W'(tw_cos(tw_idx));
        w_im   = mode ? TW_W'(tw_sin(tw_idx)) : -TW_W'(tw_sin(tw_idx));
    end

    fft_butterfly #(.AW(AW), .TW_W(TW_W)) u_bfly (
        .a_re  (arr_re[top_i]),
        .a_im  (arr_im[top_i]),
        .b_re  (arr_re[bot_i]),
        .b_im  (arr_im[bot_i]),
        .w_re  (w_re),
        .w_im  (w_im),
        .y0_re (y0_re),
        .y0_im (y0_im),
        .y1_re (y1_re),
        .y1_im (y1_im)
    );

    always_ff @(posedge clk) begin
        if (in_fire) begin
            arr_re[load_addr] <= AW'(in_re);
            arr_im[load_addr] <= AW'(in_im);
        end else if (state == ST_COMPUTE) begin
            arr_re[top_i] <= y0_re;
            arr_im[top_i] <= y0_im;
            arr_re[bot_i] <= y1_re;
            arr_im[bot_i] <= y1_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            mode      <= 1'b0;
            cnt       <= '0;
            bf        <= '0;
            stage     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
        end else begin
            case (state)
                ST_LOAD: if (in_fire) begin
                    if (cnt == '0) mode <= inverse;
                    cnt <= cnt + 1'b1;
                    if (cnt == LOG2N'(N - 1)) state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    bf <= last_bf ? '0 : bf + 1'b1;
                    if (last_bf) begin
                        if (last_stage) begin
                            stage <= '0;
                            state <= ST_UNLOAD;
                        end else begin
                            stage <= stage + 3'd1;
                        end
                    end
                end
                ST_UNLOAD: if (!out_valid || out_ready) begin
                    // cnt restarts at 0 here because it wrapped at the end of LOAD.
                    if (out_valid && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= ST_LOAD;
                    end else begin
                        out_re    <= OUT_W'(arr_re[cnt]);
                        out_im    <= OUT_W'(arr_im[cnt]);
                        out_idx   <= cnt;
                        out_last  <= (cnt == LOG2N'(N - 1));
                        out_valid <= 1'b1;
                        cnt       <= cnt + 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stream_core.sv
// tb/tb_fft_stream_core.sv - Self-checking bench for fft_stream_core against a direct DFT model
module tb_fft_stream_core;

    logic clk;
    logic rst;
    logic in_valid8, in_valid32, inverse;
    logic out_ready = 1'b1;
    logic signed [15:0] in_re, in_im;

    logic rdy8, ov8, olast8, busy8;
    logic signed [18:0] ore8, oim8;
    logic [2:0] oidx8;
    logic rdy32, ov32, olast32, busy32;
    logic signed [20:0] ore32, oim32;
    logic [4:0] oidx32;

    fft_stream_core #(.DATA_W(16), .LOG2N(3), .TW_W(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(rdy8),
        .in_re(in_re), .in_im(in_im), .inverse(inverse),
        .out_valid(ov8), .out_ready(out_ready), .out_re(ore8), .out_im(oim8),
        .out_idx(oidx8), .out_last(olast8), .busy(busy8)
    );

    fft_stream_core #(.DATA_W(16), .LOG2N(5), .TW_W(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(rdy32),
        .in_re(in_re), .in_im(in_im), .inverse(inverse),
        .out_valid(ov32), .out_ready(out_ready), .out_re(ore32), .out_im(oim32),
        .out_idx(oidx32), .out_last(olast32), .busy(busy32)
    );

    int  checks = 0, failures = 0;
    int  x_re[32], x_im[32], exp_re[32], exp_im[32], got_re[32], got_im[32];
    int  sel_n = 8, bin_k = 0, hs_count = 0;
    bit  first_seen = 0, prev_stall = 0, chk_rdy = 0, bp_mode = 0;
    int  prev_re, prev_im, prev_idx, bp_cnt = 0;
    int  c_re, c_im, c_idx;
    bit  c_v, c_last, c_rdy;
    time last_hs_time, first_valid_time;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int req, input int tol);
        checks++;
        if (act - req > tol || req - act > tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, req, tol);
        end
    endtask

    // Direct O(N^2) DFT in floating point; no scaling in either direction.
    task automatic model_dft(input int n, input bit inv);
        real sr, si, ang;
        for (int k = 0; k < n; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int m = 0; m < n; m++) begin
                ang = (inv ? 2.0 : -2.0) * 3.14159265358979 * real'((k * m) % n) / real'(n);
                sr += real'(x_re[m]) * $cos(ang) - real'(x_im[m]) * $sin(ang);
                si += real'(x_re[m]) * $sin(ang) + real'(x_im[m]) * $cos(ang);
            end
            exp_re[k] = int'(sr);
            exp_im[k] = int'(si);
        end
    endtask

    initial begin : backpressure
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = (bp_cnt % 3 == 0);
                bp_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                chk_rdy    = 0;
            end else begin
                c_v    = (sel_n == 32) ? ov32 : ov8;
                c_last = (sel_n == 32) ? olast32 : olast8;
                c_rdy  = (sel_n == 32) ? rdy32 : rdy8;
                c_re   = (sel_n == 32) ? int'(ore32) : int'(ore8);
                c_im   = (sel_n == 32) ? int'(oim32) : int'(oim8);
                c_idx  = (sel_n == 32) ? int'(oidx32) : int'(oidx8);
                if (chk_rdy) begin
                    check_eq("in_ready_after_last", int'(c_rdy), 1);
                    chk_rdy = 0;
                end
                if (prev_stall) begin
                    check_eq("stall_valid", int'(c_v), 1);
                    check_eq("stall_re", c_re, prev_re);
                    check_eq("stall_im", c_im, prev_im);
                    check_eq("stall_idx", c_idx, prev_idx);
                end
                if (c_v && !first_seen) begin
                    first_seen = 1;
                    first_valid_time = $time;
                end
                if (c_v && out_ready) begin
                    if (bin_k >= sel_n) begin
                        check_eq("extra_bin", bin_k, sel_n - 1);
                    end else begin
                        check_eq("bin_idx", c_idx, bin_k);
                        check_tol("bin_re", c_re, exp_re[bin_k], 2);
                        check_tol("bin_im", c_im, exp_im[bin_k], 2);
                        check_eq("bin_last", int'(c_last), int'(bin_k == sel_n - 1));
                        got_re[bin_k] = c_re;
                        got_im[bin_k] = c_im;
                        if (c_last) chk_rdy = 1;
                    end
                    bin_k++;
                    hs_count++;
                end
                prev_stall = c_v && !out_ready;
                prev_re    = c_re;
                prev_im    = c_im;
                prev_idx   = c_idx;
            end
        end
    end

    task automatic send_frame(input int n, input bit inv, input bit hold);
        int guard;
        @(negedge clk);
        model_dft(n, inv);
        sel_n = n; bin_k = 0; hs_count = 0; first_seen = 0; prev_stall = 0;
        for (int k = 0; k < 32; k++) begin
            got_re[k] = -999999;
            got_im[k] = -999999;
        end
        for (int i = 0; i < n; i++) begin
            if (n == 32) in_valid32 = 1'b1; else in_valid8 = 1'b1;
            in_re   = 16'(x_re[i]);
            in_im   = 16'(x_im[i]);
            inverse = (i == 0) ? inv : !inv;
            guard = 0;
            while (!((n == 32) ? rdy32 : rdy8) && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 500) check_eq("in_ready_timeout", guard, 0);
            @(posedge clk);
            last_hs_time = $time;
            @(negedge clk);
        end
        if (hold) begin
            in_re = 16'sd12345;
            check_eq("in_ready_in_compute", int'((n == 32) ? rdy32 : rdy8), 0);
            check_eq("busy_in_compute", int'((n == 32) ? busy32 : busy8), 1);
            repeat (3) @(negedge clk);
        end
        in_valid8  = 1'b0;
        in_valid32 = 1'b0;
    endtask

    task automatic wait_frame(input int n);
        int guard = 0;
        int lat   = ((n / 2) * ((n == 32) ? 5 : 3) + 1) * 10 + 5;
        while (hs_count < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check_eq("handshakes", hs_count, n);
        check_eq("latency", int'(first_valid_time - last_hs_time), lat);
    endtask

    initial begin : main
        rst = 1'b1; in_valid8 = 1'b0; in_valid32 = 1'b0;
        in_re = '0; in_im = '0; inverse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", int'(ov8), 0);
        check_eq("rst_out_last", int'(olast8), 0);
        check_eq("rst_out_re", int'(ore8), 0);
        check_eq("rst_out_im", int'(oim8), 0);
        check_eq("rst_out_idx", int'(oidx8), 0);
        check_eq("rst_busy", int'(busy8), 0);
        check_eq("rst_busy32", int'(busy32), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst", int'(rdy8), 1);
        check_eq("in_ready32_after_rst", int'(rdy32), 1);

        // Impulse, forward, in_valid held high past the last sample
        for (int i = 0; i < 8; i++) begin x_re[i] = (i == 0) ? 1000 : 0; x_im[i] = 0; end
        send_frame(8, 0, 1); wait_frame(8);
        check_eq("impulse_x0_re", got_re[0], 1000);
        check_eq("impulse_x6_re", got_re[6], 1000);
        check_eq("impulse_x6_im", got_im[6], 0);

        // DC
        for (int i = 0; i < 8; i++) begin x_re[i] = 4095; x_im[i] = 0; end
        send_frame(8, 0, 0); wait_frame(8);
        check_eq("dc_x0", got_re[0], 32760);
        check_eq("dc_x1", got_re[1], 0);
        check_eq("dc_x7_im", got_im[7], 0);

        // Alternating, forward then inverse
        for (int i = 0; i < 8; i++) begin x_re[i] = (i % 2 == 0) ? 1000 : -1000; x_im[i] = 0; end
        send_frame(8, 0, 0); wait_frame(8);
        check_eq("alt_x4", got_re[4], 8000);
        check_eq("alt_x0", got_re[0], 0);
        send_frame(8, 1, 0); wait_frame(8);
        check_eq("alt_inv_x4", got_re[4], 8000);

        // Inverse of a constant
        for (int i = 0; i < 8; i++) begin x_re[i] = 1000; x_im[i] = 0; end
        send_frame(8, 1, 0); wait_frame(8);
        check_eq("inv_const_x0", got_re[0], 8000);
        check_eq("inv_const_x4", got_re[4], 0);

        // Cosine at bin 1
        x_re = '{1000, 707, 0, -707, -1000, -707, 0, 707,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) x_im[i] = 0;
        send_frame(8, 0, 0); wait_frame(8);
        check_tol("cos_x1", got_re[1], 4000, 2);
        check_tol("cos_x7", got_re[7], 4000, 2);
        check_tol("cos_x1_im", got_im[1], 0, 2);

        // Backpressure with a complex ramp so every bin is distinct
        for (int i = 0; i < 8; i++) begin x_re[i] = 100 * i; x_im[i] = 50 - 10 * i; end
        bp_mode = 1;
        send_frame(8, 0, 0); wait_frame(8);
        bp_mode = 0;
        check_tol("ramp_x0", got_re[0], 2800, 2);

        // Reset in the middle of COMPUTE, then a clean impulse frame
        send_frame(8, 0, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_busy", int'(busy8), 0);
        check_eq("midrst_out_valid", int'(ov8), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_in_ready", int'(rdy8), 1);
        for (int i = 0; i < 8; i++) begin x_re[i] = (i == 0) ? 1000 : 0; x_im[i] = 0; end
        send_frame(8, 0, 0); wait_frame(8);
        check_eq("post_rst_x3", got_re[3], 1000);

        // DC on the 32-point instance
        for (int i = 0; i < 32; i++) begin x_re[i] = 4095; x_im[i] = 0; end
        send_frame(32, 0, 0); wait_frame(32);
        check_eq("dc32_x0", got_re[0], 131040);
        check_eq("dc32_x16", got_re[16], 0);
        check_eq("idle8_after_n32", int'(ov8), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
